// File: rtl/vend_ctrl_param_pkg.sv
// Shared types for the vending controller: FSM states, display-mode codes
// and a small bit-count helper.
package vend_pkg;

    typedef enum logic [2:0] {
        S_ID   = 3'd0,
        S_RUN  = 3'd1,
        S_VEND = 3'd2,
        S_ERR  = 3'd3,
        S_ZERO = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        ID     = 3'd0,
        NORMAL = 3'd1,
        ZERO   = 3'd2,
        ERR    = 3'd3,
        REPORT = 3'd4
    } disp_mode_e;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/vend_ctrl_param_if.sv
// Board-side bundle of the vending controller: raw switches/button in,
// binary display values and status out.
interface vend_ctrl_param_if
    import vend_pkg::*;
#(
    parameter int NUM_COIN = 4,
    parameter int VAL_W    = 8,
    parameter int CNT_W    = 4
);
    logic                enter_n;
    logic [NUM_COIN-1:0] coin_sel;
    logic                card;
    logic                clear;
    logic                report;
    logic [VAL_W-1:0]    deposit;
    logic [VAL_W-1:0]    change;
    logic [CNT_W-1:0]    dispensed;
    disp_mode_e          disp_mode;
    logic                error;
    logic                led_flash;

    modport master (
        output enter_n, coin_sel, card, clear, report,
        input  deposit, change, dispensed, disp_mode, error, led_flash
    );

    modport slave (
        input  enter_n, coin_sel, card, clear, report,
        output deposit, change, dispensed, disp_mode, error, led_flash
    );
endinterface

// File: rtl/vend_flash_timer.sv
// LED flasher: while enabled, goes high one clock after enable rises and
// then toggles every FLASH_HALF clocks; held low and cleared otherwise.
module vend_flash_timer #(
    parameter int FLASH_HALF = 6000000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic led_flash
);
    localparam int              CW   = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [CW-1:0]   LAST = CW'(FLASH_HALF - 1);

    logic [CW-1:0] r_cnt;
    logic          r_started;
    logic          r_led;

    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            r_cnt     <= '0;
            r_started <= 1'b0;
            r_led     <= 1'b0;
        end else if (!r_started) begin
            r_started <= 1'b1;
            r_led     <= 1'b1;
            r_cnt     <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
            r_led <= ~r_led;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign led_flash = r_led;
endmodule

// File: rtl/vend_ctrl_param.sv
// Vending-machine controller: synchronised inputs, enter-edge pulse, credit
// FSM with repeat-limit errors, and the vend LED flasher.
module vend_ctrl_param
    import vend_pkg::*;
#(
    parameter int                    PRICE       = 35,
    parameter int                    NUM_COIN    = 4,
    parameter logic [NUM_COIN*8-1:0] COIN_VALUES = {8'd100, 8'd25, 8'd10, 8'd5},
    parameter int                    BIG_COIN    = 3,
    parameter int                    MAX_REPEAT  = 2,
    parameter int                    VAL_W       = 8,
    parameter int                    CNT_W       = 4,
    parameter int                    FLASH_HALF  = 6000000
) (
    input  logic              clock,
    input  logic              reset,
    vend_ctrl_param_if.slave  bus
);
    function automatic int max_coin();
        int m;
        m = 0;
        for (int i = 0; i < NUM_COIN; i++) begin
            if (int'(COIN_VALUES[i*8 +: 8]) > m) m = int'(COIN_VALUES[i*8 +: 8]);
        end
        return m;
    endfunction

    localparam int               MAX_COIN = max_coin();
    localparam int               RW       = $clog2(MAX_REPEAT + 1);
    localparam logic [RW-1:0]    REP_LIM  = RW'(MAX_REPEAT);
    localparam logic [VAL_W-1:0] PRICE_V  = VAL_W'(PRICE);

    generate
        if (PRICE + MAX_COIN >= 2**VAL_W) begin : g_width_chk
            $error("vend_ctrl_param: VAL_W too narrow for PRICE + largest coin");
        end
    endgenerate

    logic                r_enter_s1, r_enter_s2, r_enter_prev, r_enter_p;
    logic [NUM_COIN-1:0] r_coin_s1, r_coin_s2;
    logic                r_card_s1, r_card_s2, r_clear_s1, r_clear_s2;

    state_e              r_state;
    logic [VAL_W-1:0]    r_deposit, r_change;
    logic [CNT_W-1:0]    r_dispensed;
    logic [RW-1:0]       r_big_rep, r_card_rep;

    int unsigned         w_sel_cnt;
    logic [VAL_W-1:0]    w_add, w_base_dep, w_base_chg, w_sum;
    logic [RW-1:0]       w_big_nxt, w_card_nxt;
    logic                w_rep_hit, w_vend;
    disp_mode_e          w_mode;

    // enter_n idles high so a reset never looks like a press
    always_ff @(posedge clock) begin
        if (reset) begin
            r_enter_s1   <= 1'b1;
            r_enter_s2   <= 1'b1;
            r_enter_prev <= 1'b1;
            r_enter_p    <= 1'b0;
            r_coin_s1    <= '0;
            r_coin_s2    <= '0;
            r_card_s1    <= 1'b0;
            r_card_s2    <= 1'b0;
            r_clear_s1   <= 1'b0;
            r_clear_s2   <= 1'b0;
        end else begin
            r_enter_s1   <= bus.enter_n;
            r_enter_s2   <= r_enter_s1;
            r_enter_prev <= r_enter_s2;
            r_enter_p    <= r_enter_prev & ~r_enter_s2;
            r_coin_s1    <= bus.coin_sel;
            r_coin_s2    <= r_coin_s1;
            r_card_s1    <= bus.card;
            r_card_s2    <= r_card_s1;
            r_clear_s1   <= bus.clear;
            r_clear_s2   <= r_clear_s1;
        end
    end

    // A vend state starts every entry from an empty deposit
    always_comb begin
        w_sel_cnt  = popcount(32'({r_coin_s2, r_card_s2, r_clear_s2}));
        w_add      = '0;
        for (int i = 0; i < NUM_COIN; i++) begin
            if (r_coin_s2[i]) w_add = w_add | VAL_W'(COIN_VALUES[i*8 +: 8]);
        end
        if (r_card_s2) w_add = w_add | PRICE_V;
        w_base_dep = (r_state == S_VEND) ? '0 : r_deposit;
        w_base_chg = (r_state == S_VEND) ? '0 : r_change;
        w_sum      = w_base_dep + w_add;
        if (r_card_s2) begin
            w_card_nxt = r_card_rep + 1'b1;
            w_big_nxt  = '0;
        end else begin
            w_card_nxt = '0;
            w_big_nxt  = r_coin_s2[BIG_COIN] ? r_big_rep + 1'b1 : '0;
        end
        w_rep_hit  = (w_big_nxt == REP_LIM) || (w_card_nxt == REP_LIM);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_ID;
            r_deposit   <= '0;
            r_change    <= '0;
            r_dispensed <= '0;
            r_big_rep   <= '0;
            r_card_rep  <= '0;
        end else if (r_enter_p && !bus.report) begin
            case (r_state)
                S_ID: begin
                    r_state   <= S_RUN;
                    r_deposit <= '0;
                    r_change  <= '0;
                end
                S_ERR: begin
                    r_state    <= S_ZERO;
                    r_deposit  <= '0;
                    r_change   <= '0;
                    r_big_rep  <= '0;
                    r_card_rep <= '0;
                end
                S_ZERO: r_state <= S_RUN;
                S_RUN, S_VEND: begin
                    if (w_sel_cnt == 0) begin
                        r_state   <= S_RUN;
                        r_deposit <= w_base_dep;
                        r_change  <= w_base_chg;
                    end else if (w_sel_cnt > 1) begin
                        r_state   <= S_ERR;
                        r_deposit <= w_base_dep;
                        r_change  <= w_base_chg;
                    end else if (r_clear_s2) begin
                        r_state    <= S_RUN;
                        r_deposit  <= '0;
                        r_change   <= '0;
                        r_big_rep  <= '0;
                        r_card_rep <= '0;
                    end else begin
                        r_big_rep  <= w_big_nxt;
                        r_card_rep <= w_card_nxt;
                        if (w_rep_hit) begin
                            r_state   <= S_ERR;
                            r_deposit <= w_base_dep;
                            r_change  <= w_base_chg;
                        end else if (w_sum >= PRICE_V) begin
                            r_state     <= S_VEND;
                            r_deposit   <= PRICE_V;
                            r_change    <= w_sum - PRICE_V;
                            r_dispensed <= r_dispensed + 1'b1;
                        end else begin
                            r_state   <= S_RUN;
                            r_deposit <= w_sum;
                            r_change  <= w_base_chg;
                        end
                    end
                end
                default: r_state <= S_ID;
            endcase
        end
    end

    always_comb begin
        w_mode = NORMAL;
        if (r_state == S_ID)       w_mode = ID;
        else if (r_state == S_ERR) w_mode = ERR;
        else if (bus.report)       w_mode = REPORT;
        else if (r_state == S_ZERO) w_mode = ZERO;
    end

    assign w_vend        = (r_state == S_VEND);
    assign bus.deposit   = r_deposit;
    assign bus.change    = r_change;
    assign bus.dispensed = r_dispensed;
    assign bus.disp_mode = w_mode;
    assign bus.error     = (r_state == S_ERR);

    vend_flash_timer #(.FLASH_HALF(FLASH_HALF)) u_flash (
        .clock     (clock),
        .reset     (reset),
        .enable    (w_vend),
        .led_flash (bus.led_flash)
    );
endmodule

// File: tb/tb_vend_ctrl_param.sv
// Directed bench for vend_ctrl_param: a vector table of button presses plus
// hand sequences for LED flashing, counter wrap and reset during a press.
module tb_vend_ctrl_param;
    import vend_pkg::*;

    logic clock;
    logic reset;
    int   n_pass;
    int   n_chk;

    vend_ctrl_param_if #(.NUM_COIN(4), .VAL_W(8), .CNT_W(4)) bus ();

    vend_ctrl_param #(
        .PRICE      (35),
        .NUM_COIN   (4),
        .COIN_VALUES({8'd100, 8'd25, 8'd10, 8'd5}),
        .BIG_COIN   (3),
        .MAX_REPEAT (2),
        .VAL_W      (8),
        .CNT_W      (4),
        .FLASH_HALF (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] coin;
        logic       card;
        logic       clr;
        logic       rpt;
        int         dep;
        int         chg;
        int         cnt;
        int         mode;
    } vec_t;

    localparam logic [3:0] NICKEL  = 4'b0001;
    localparam logic [3:0] DIME    = 4'b0010;
    localparam logic [3:0] QUARTER = 4'b0100;
    localparam logic [3:0] DOLLAR  = 4'b1000;

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset        = 1'b1;
        bus.enter_n  = 1'b1;
        bus.coin_sel = '0;
        bus.card     = 1'b0;
        bus.clear    = 1'b0;
        bus.report   = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic press(input logic [3:0] c, input logic cd, input logic cl, input logic rp);
        @(negedge clock);
        bus.coin_sel = c;
        bus.card     = cd;
        bus.clear    = cl;
        bus.report   = rp;
        bus.enter_n  = 1'b0;
        repeat (6) @(negedge clock);
        bus.enter_n  = 1'b1;
        repeat (6) @(negedge clock);
    endtask

    vec_t tbl[24];

    initial begin
        n_pass = 0;
        n_chk  = 0;
        reset  = 1'b1;

        tbl[0]  = '{4'b0000, 1'b0, 1'b0, 1'b0,  0,  0, 0, 1};
        tbl[1]  = '{QUARTER, 1'b0, 1'b0, 1'b0, 25,  0, 0, 1};
        tbl[2]  = '{DIME,    1'b0, 1'b0, 1'b0, 35,  0, 1, 1};
        tbl[3]  = '{DOLLAR,  1'b0, 1'b0, 1'b0, 35, 65, 2, 1};
        tbl[4]  = '{NICKEL,  1'b0, 1'b0, 1'b0,  5,  0, 2, 1};
        tbl[5]  = '{DOLLAR,  1'b0, 1'b0, 1'b0, 35, 70, 3, 1};
        tbl[6]  = '{DOLLAR,  1'b0, 1'b0, 1'b0,  0,  0, 3, 3};
        tbl[7]  = '{4'b0000, 1'b0, 1'b0, 1'b0,  0,  0, 3, 2};
        tbl[8]  = '{4'b0000, 1'b0, 1'b0, 1'b0,  0,  0, 3, 1};
        tbl[9]  = '{DIME,    1'b0, 1'b0, 1'b0, 10,  0, 3, 1};
        tbl[10] = '{4'b0011, 1'b0, 1'b0, 1'b0, 10,  0, 3, 3};
        tbl[11] = '{4'b0000, 1'b0, 1'b0, 1'b0,  0,  0, 3, 2};
        tbl[12] = '{4'b0000, 1'b0, 1'b0, 1'b0,  0,  0, 3, 1};
        tbl[13] = '{4'b0000, 1'b1, 1'b0, 1'b0, 35,  0, 4, 1};
        tbl[14] = '{4'b0000, 1'b1, 1'b0, 1'b0,  0,  0, 4, 3};
        tbl[15] = '{4'b0000, 1'b0, 1'b1, 1'b0,  0,  0, 4, 2};
        tbl[16] = '{4'b0000, 1'b0, 1'b0, 1'b0,  0,  0, 4, 1};
        tbl[17] = '{4'b0000, 1'b0, 1'b1, 1'b0,  0,  0, 4, 1};
        tbl[18] = '{QUARTER, 1'b0, 1'b0, 1'b1,  0,  0, 4, 4};
        tbl[19] = '{QUARTER, 1'b0, 1'b0, 1'b0, 25,  0, 4, 1};
        tbl[20] = '{4'b0000, 1'b1, 1'b1, 1'b0, 25,  0, 4, 3};
        tbl[21] = '{QUARTER, 1'b0, 1'b0, 1'b0,  0,  0, 4, 2};
        tbl[22] = '{4'b0000, 1'b0, 1'b0, 1'b1,  0,  0, 4, 4};
        tbl[23] = '{4'b0000, 1'b0, 1'b0, 1'b0,  0,  0, 4, 1};

        do_reset();
        chk("reset.dep",   int'(bus.deposit),   0);
        chk("reset.chg",   int'(bus.change),    0);
        chk("reset.cnt",   int'(bus.dispensed), 0);
        chk("reset.mode",  int'(bus.disp_mode), 0);
        chk("reset.err",   int'(bus.error),     0);
        chk("reset.led",   int'(bus.led_flash), 0);

        for (int i = 0; i < 24; i++) begin
            press(tbl[i].coin, tbl[i].card, tbl[i].clr, tbl[i].rpt);
            chk($sformatf("v%0d.dep", i),  int'(bus.deposit),   tbl[i].dep);
            chk($sformatf("v%0d.chg", i),  int'(bus.change),    tbl[i].chg);
            chk($sformatf("v%0d.cnt", i),  int'(bus.dispensed), tbl[i].cnt);
            chk($sformatf("v%0d.mode", i), int'(bus.disp_mode), tbl[i].mode);
            chk($sformatf("v%0d.err", i),  int'(bus.error),     (tbl[i].mode == 3) ? 1 : 0);
        end

        // Vend by quarter+dime with cycle-exact latency and LED pattern
        do_reset();
        press(4'b0000, 1'b0, 1'b0, 1'b0);
        press(QUARTER, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        bus.coin_sel = DIME;
        bus.enter_n  = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (k == 3) chk("lat.dep_before", int'(bus.deposit), 25);
            if (k == 4) begin
                chk("lat.dep_after", int'(bus.deposit),   35);
                chk("lat.cnt_after", int'(bus.dispensed), 1);
            end
            if (k == 8) bus.enter_n = 1'b1;
            chk($sformatf("flash.k%0d", k), int'(bus.led_flash),
                (k >= 5 && (((k - 5) / 4) % 2 == 0)) ? 1 : 0);
        end
        press(NICKEL, 1'b0, 1'b0, 1'b0);
        chk("flash.off_led", int'(bus.led_flash), 0);
        chk("flash.off_dep", int'(bus.deposit),   5);

        // Dispensed counter wraps after 16 vends
        do_reset();
        press(4'b0000, 1'b0, 1'b0, 1'b0);
        for (int p = 1; p <= 16; p++) begin
            press(QUARTER, 1'b0, 1'b0, 1'b0);
            press(DIME, 1'b0, 1'b0, 1'b0);
            if (p == 15) chk("wrap.cnt15", int'(bus.dispensed), 15);
            if (p == 16) begin
                chk("wrap.cnt0", int'(bus.dispensed), 0);
                chk("wrap.dep",  int'(bus.deposit),   35);
            end
        end

        // Reset coinciding with the enter pulse while vending
        do_reset();
        press(4'b0000, 1'b0, 1'b0, 1'b0);
        for (int p = 0; p < 3; p++) begin
            press(QUARTER, 1'b0, 1'b0, 1'b0);
            press(DIME, 1'b0, 1'b0, 1'b0);
        end
        chk("rst.pre_cnt", int'(bus.dispensed), 3);
        @(negedge clock);
        bus.coin_sel = QUARTER;
        bus.enter_n  = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rst.dep",  int'(bus.deposit),   0);
        chk("rst.chg",  int'(bus.change),    0);
        chk("rst.cnt",  int'(bus.dispensed), 0);
        chk("rst.mode", int'(bus.disp_mode), 0);
        chk("rst.led",  int'(bus.led_flash), 0);
        chk("rst.err",  int'(bus.error),     0);
        reset       = 1'b0;
        bus.enter_n = 1'b1;
        repeat (8) @(negedge clock);
        chk("rst.hold_mode", int'(bus.disp_mode), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
